// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the MIPS W stage.
// Holds the reset PC, register-file geometry and the M/W register layout.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam int          REG_AW   = 5;
  localparam int          NREG     = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    word_t     pc;
    word_t     instr;
    word_t     wd;
    reg_addr_t a3;
    logic      reg_write;
    logic      valid;
  } mw_reg_t;

  // Contents of the M/W register for a bubble (also the reset value).
  function automatic mw_reg_t mw_bubble(word_t pc);
    mw_reg_t b;
    b           = '0;
    b.pc        = pc;
    return b;
  endfunction

endpackage

// File: rtl/mw_writeback_if.sv
// M-stage inputs, D-stage read ports and W-stage outputs of the writeback stage.
// The pipeline (master) drives M_* / control / D_A*; the W stage (slave) answers.
interface mw_writeback_if;
  import cpu_pkg::*;

  logic      M_valid;
  word_t     M_PC;
  word_t     M_instr;
  word_t     M_WD_W;
  reg_addr_t M_A3;
  logic      M_RegWrite;
  logic      W_stall;
  logic      W_flush;
  reg_addr_t D_A1;
  reg_addr_t D_A2;
  word_t     D_RD1;
  word_t     D_RD2;
  word_t     W_PC;
  word_t     W_instr;
  word_t     W_WD;
  reg_addr_t W_A3;
  logic      W_RegWrite;
  logic      W_valid;
  word_t     retire_cnt;

  modport master (
    output M_valid, M_PC, M_instr, M_WD_W, M_A3, M_RegWrite,
    output W_stall, W_flush, D_A1, D_A2,
    input  D_RD1, D_RD2, W_PC, W_instr, W_WD, W_A3, W_RegWrite, W_valid, retire_cnt
  );

  modport slave (
    input  M_valid, M_PC, M_instr, M_WD_W, M_A3, M_RegWrite,
    input  W_stall, W_flush, D_A1, D_A2,
    output D_RD1, D_RD2, W_PC, W_instr, W_WD, W_A3, W_RegWrite, W_valid, retire_cnt
  );

endinterface

// File: rtl/grf_bypass.sv
// General register file: one write port, two combinational read ports with
// write-through bypass; register 0 reads as zero and is never written.
module grf_bypass
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  logic      byp_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output word_t     rd_data1,
  output word_t     rd_data2
);

  word_t regs_q [NREG];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en && wr_addr != REG_ZERO) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: outputs get an unconditional default first so no path infers a latch.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (byp_en && wr_addr == rd_addr1) rd_data1 = wr_data;
    if (rd_addr1 == REG_ZERO)          rd_data1 = '0;

    rd_data2 = regs_q[rd_addr2];
    if (byp_en && wr_addr == rd_addr2) rd_data2 = wr_data;
    if (rd_addr2 == REG_ZERO)          rd_data2 = '0;
  end

endmodule

// File: rtl/mw_writeback.sv
// MIPS W stage: M/W pipeline register, GRF commit with bypassed D-stage reads.
// Optional retired-instruction counter enabled by defining MW_RETIRE_CNT_EN.
module mw_writeback #(
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
  parameter int          NREG     = cpu_pkg::NREG
) (
  input  logic           clk,
  input  logic           reset,
  mw_writeback_if.slave  bus
);
  import cpu_pkg::*;

  mw_reg_t mw_q, mw_d;
  logic    m_writes;

  always_comb begin
    m_writes = bus.M_RegWrite & bus.M_valid & (bus.M_A3 != REG_ZERO);
    mw_d     = mw_q;
    if (bus.W_flush) begin
      mw_d = mw_bubble(PC_RESET);
    end else if (!bus.W_stall) begin
      mw_d.pc        = bus.M_PC;
      mw_d.instr     = bus.M_instr;
      mw_d.wd        = bus.M_WD_W;
      mw_d.a3        = m_writes ? bus.M_A3 : REG_ZERO;
      mw_d.reg_write = m_writes;
      mw_d.valid     = bus.M_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) mw_q <= mw_bubble(PC_RESET);
    else        mw_q <= mw_d;
  end

  // Bypass follows the held W instruction during a stall; the commit waits for release.
  grf_bypass #(.NREG(NREG)) u_grf (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (mw_q.reg_write & ~bus.W_stall),
    .byp_en   (mw_q.reg_write),
    .wr_addr  (mw_q.a3),
    .wr_data  (mw_q.wd),
    .rd_addr1 (bus.D_A1),
    .rd_addr2 (bus.D_A2),
    .rd_data1 (bus.D_RD1),
    .rd_data2 (bus.D_RD2)
  );

  assign bus.W_PC       = mw_q.pc;
  assign bus.W_instr    = mw_q.instr;
  assign bus.W_WD       = mw_q.wd;
  assign bus.W_A3       = mw_q.a3;
  assign bus.W_RegWrite = mw_q.reg_write;
  assign bus.W_valid    = mw_q.valid;

`ifdef MW_RETIRE_CNT_EN
  word_t retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {{(XLEN-1){1'b0}}, (mw_q.valid & ~bus.W_stall)};
  end

  always_ff @(posedge clk) begin
    if (!reset) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign bus.retire_cnt = retire_cnt_q;
`else
  assign bus.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mw_writeback.sv
// Directed bench for mw_writeback: reset, stall/flush corner sequences and a
// table of load/commit/bypass vectors with hand-computed expectations.
module tb_mw_writeback;

`ifdef MW_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_retire = '0;

  mw_writeback_if bus ();

  mw_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        m_valid;
    logic [31:0] pc, instr, wd;
    logic [4:0]  a3;
    logic        rw;
    logic [4:0]  a1, a2;
    logic        e_valid, e_rw;
    logic [4:0]  e_a3;
    logic [31:0] e_rd1, e_rd2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_m(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] wd, input logic [4:0] a3, input logic rw);
    bus.M_valid    = v;
    bus.M_PC       = pc;
    bus.M_instr    = instr;
    bus.M_WD_W     = wd;
    bus.M_A3       = a3;
    bus.M_RegWrite = rw;
  endtask

  // One rising edge; the retire model advances on the same condition the counter uses.
  task automatic tick();
    if (!reset)                                    exp_retire = '0;
    else if (CNT_EN && exp_valid && !bus.W_stall)  exp_retire = exp_retire + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " W_PC"},       bus.W_PC, 32'h0000_3000);
    check({tag, " W_instr"},    bus.W_instr, 32'h0);
    check({tag, " W_WD"},       bus.W_WD, 32'h0);
    check({tag, " W_A3"},       32'(bus.W_A3), 32'h0);
    check({tag, " W_RegWrite"}, 32'(bus.W_RegWrite), 32'h0);
    check({tag, " W_valid"},    32'(bus.W_valid), 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h3020, 32'h3C08_0001, 32'h1234_5678, 5'd8,  1'b1, 5'd8,  5'd0,
                1'b1, 1'b1, 5'd8, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b1, 32'h3024, 32'h2000_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b1, 5'd8,  5'd0,
                1'b1, 1'b0, 5'd0, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 32'h3028, 32'h2409_00AA, 32'h0000_00AA, 5'd9,  1'b1, 5'd9,  5'd8,
                1'b1, 1'b1, 5'd9, 32'h0000_00AA, 32'h1234_5678};
    vecs[3] = '{1'b0, 32'h302C, 32'h0123_4567, 32'h0000_0055, 5'd10, 1'b1, 5'd10, 5'd9,
                1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_00AA};
    vecs[4] = '{1'b1, 32'h3030, 32'hAC05_0000, 32'h0000_0077, 5'd5,  1'b0, 5'd5,  5'd5,
                1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 32'h3034, 32'h8C08_0004, 32'hDEAD_BEEF, 5'd8,  1'b1, 5'd8,  5'd8,
                1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 32'h3038, 32'h8C08_0008, 32'hCAFE_F00D, 5'd8,  1'b1, 5'd8,  5'd9,
                1'b1, 1'b1, 5'd8, 32'hCAFE_F00D, 32'h0000_00AA};

    drive_m(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.W_stall = 1'b0;
    bus.W_flush = 1'b0;
    bus.D_A1    = 5'd5;
    bus.D_A2    = 5'd0;

    // Reset for two cycles, then release.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_bubble("reset");
    check("reset D_RD1 A1=5", bus.D_RD1, 32'h0);
    check("reset retire_cnt", bus.retire_cnt, 32'h0);

    // Stall holds a pending write to $9; commit lands on the first free edge.
    drive_m(1'b1, 32'h3000, 32'h2409_00AA, 32'h0000_00AA, 5'd9, 1'b1);
    bus.D_A1 = 5'd9;
    tick();
    exp_valid = 1'b1;
    check("load W_A3", 32'(bus.W_A3), 32'd9);
    check("load W_RegWrite", 32'(bus.W_RegWrite), 32'd1);
    check("load bypass D_RD1", bus.D_RD1, 32'hAA);

    drive_m(1'b1, 32'h3004, 32'h2404_0044, 32'h0000_0044, 5'd4, 1'b1);
    bus.W_stall = 1'b1;
    bus.D_A2    = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall W_A3", 32'(bus.W_A3), 32'd9);
      check("stall W_WD", bus.W_WD, 32'hAA);
      check("stall W_PC", bus.W_PC, 32'h3000);
      check("stall W_valid", 32'(bus.W_valid), 32'd1);
      check("stall bypass D_RD1", bus.D_RD1, 32'hAA);
      check("stall D_RD2 A2=4", bus.D_RD2, 32'h0);
      check("stall retire_cnt", bus.retire_cnt, exp_retire);
    end

    bus.W_stall = 1'b0;
    drive_m(1'b0, 32'h3008, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    exp_valid = 1'b0;
    check("unstall W_valid", 32'(bus.W_valid), 32'd0);
    check("unstall W_PC", bus.W_PC, 32'h3008);
    check("unstall GRF[9]", bus.D_RD1, 32'hAA);
    check("unstall D_RD2 A2=4", bus.D_RD2, 32'h0);
    check("unstall retire_cnt", bus.retire_cnt, exp_retire);

    // Flush together with stall: bubble wins and the held $7 write is dropped.
    drive_m(1'b1, 32'h300C, 32'h2407_0077, 32'h0000_0077, 5'd7, 1'b1);
    tick();
    exp_valid = 1'b1;
    check("pre-flush W_A3", 32'(bus.W_A3), 32'd7);
    drive_m(1'b1, 32'h3010, 32'h2403_0033, 32'h0000_0033, 5'd3, 1'b1);
    bus.W_stall = 1'b1;
    bus.W_flush = 1'b1;
    bus.D_A1    = 5'd7;
    bus.D_A2    = 5'd3;
    tick();
    exp_valid = 1'b0;
    check_bubble("flush");
    check("flush GRF[7]", bus.D_RD1, 32'h0);
    check("flush GRF[3]", bus.D_RD2, 32'h0);
    bus.W_stall = 1'b0;
    bus.W_flush = 1'b0;
    drive_m(1'b0, 32'h3014, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check("post-flush GRF[7]", bus.D_RD1, 32'h0);
    check("post-flush GRF[3]", bus.D_RD2, 32'h0);
    check("post-flush retire_cnt", bus.retire_cnt, exp_retire);

    // Table of load / commit / bypass vectors.
    for (int i = 0; i < 7; i++) begin
      drive_m(vecs[i].m_valid, vecs[i].pc, vecs[i].instr, vecs[i].wd, vecs[i].a3, vecs[i].rw);
      bus.D_A1 = vecs[i].a1;
      bus.D_A2 = vecs[i].a2;
      tick();
      exp_valid = vecs[i].e_valid;
      check($sformatf("vec%0d W_valid", i),    32'(bus.W_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d W_RegWrite", i), 32'(bus.W_RegWrite), 32'(vecs[i].e_rw));
      check($sformatf("vec%0d W_A3", i),       32'(bus.W_A3), 32'(vecs[i].e_a3));
      check($sformatf("vec%0d W_WD", i),       bus.W_WD, vecs[i].wd);
      check($sformatf("vec%0d W_PC", i),       bus.W_PC, vecs[i].pc);
      check($sformatf("vec%0d W_instr", i),    bus.W_instr, vecs[i].instr);
      check($sformatf("vec%0d D_RD1", i),      bus.D_RD1, vecs[i].e_rd1);
      check($sformatf("vec%0d D_RD2", i),      bus.D_RD2, vecs[i].e_rd2);
      check($sformatf("vec%0d retire_cnt", i), bus.retire_cnt, exp_retire);
    end

    // Reset mid-stream with a write pending in W: nothing commits, all state clears.
    drive_m(1'b1, 32'h3100, 32'h240C_0012, 32'h0000_0012, 5'd12, 1'b1);
    tick();
    exp_valid = 1'b1;
    check("mid W_RegWrite", 32'(bus.W_RegWrite), 32'd1);
    reset = 1'b0;
    drive_m(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    exp_valid = 1'b0;
    reset = 1'b1;
    bus.D_A1 = 5'd12;
    bus.D_A2 = 5'd8;
    #1;
    check_bubble("mid-reset");
    check("mid-reset GRF[12]", bus.D_RD1, 32'h0);
    check("mid-reset GRF[8]", bus.D_RD2, 32'h0);
    check("mid-reset retire_cnt", bus.retire_cnt, 32'h0);
    bus.D_A1 = 5'd9;
    #1;
    check("mid-reset GRF[9]", bus.D_RD1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mw_writeback.md
Name: mw_writeback

Overview:
- W stage of the 5-stage MIPS pipeline, directly downstream of the M stage.
- Latches M-stage results (PC, instr, write data, destination, write enable) into the M/W pipeline register.
- Commits to the 32x32 general register file (GRF) and supplies D-stage read ports with write-through bypass.
- Exports W-stage values for the forwarding network.

Parameters:
- PC_RESET, 32'h0000_3000, W_PC value after reset and for bubbles.
- NREG, 32, number of GRF registers; register 0 is hardwired to zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- M_valid  in  1  M stage holds a real instruction (0 = bubble).
- M_PC  in  32  PC of the M-stage instruction.
- M_instr  in  32  M-stage instruction word.
- M_WD_W  in  32  M-stage write-back data (ALU result or load data, already selected).
- M_A3  in  5  destination register from the M-stage controller.
- M_RegWrite  in  1  M-stage instruction writes the GRF.
- W_stall  in  1  hold the M/W register and suppress commit.
- W_flush  in  1  load a bubble into the M/W register.
- D_A1  in  5  D-stage read address 1.
- D_A2  in  5  D-stage read address 2.
- D_RD1  out  32  GRF read data 1, bypassed.
- D_RD2  out  32  GRF read data 2, bypassed.
- W_PC  out  32  registered PC.
- W_instr  out  32  registered instruction.
- W_WD  out  32  registered write data, also the forwarding value.
- W_A3  out  5  registered destination, forced to 0 when not writing.
- W_RegWrite  out  1  registered write enable, qualified by valid.
- W_valid  out  1  registered valid.
- retire_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (reset==0 at rising clk):
  - W_PC=PC_RESET; W_instr=0, W_WD=0, W_A3=0, W_RegWrite=0, W_valid=0.
  - All GRF registers cleared to 0; retire_cnt=0.
  - Reset overrides stall and flush.
- Per rising clk, priority order when reset==1:
  - W_flush=1 → bubble: valid=0, RegWrite=0, A3=0, WD=0, instr=0, PC=PC_RESET. Flush wins over stall.
  - else W_stall=1 → all W_* registers hold.
  - else load M_* inputs. W_RegWrite = M_RegWrite & M_valid & (M_A3!=0). W_A3 = M_A3 when that term is 1, else 0.
- Latency: an instruction in M at edge k appears on W_* after edge k; the GRF is written at edge k+1.
- GRF commit at rising clk when reset==1, W_RegWrite=1 and W_stall=0: GRF[W_A3] <= W_WD. Register 0 is never written. A stalled W instruction commits on the first unstalled edge.
- Reads are combinational. D_RDn = 0 if D_An==0; else W_WD if W_RegWrite && W_A3==D_An; else GRF[D_An]. The bypass applies even while W_stall=1.
- Both read ports may hit the same address or bypass simultaneously; no ordering hazard.
- No internal state machine beyond the pipeline register, GRF and counter. Outputs change only on clk, except D_RD1/D_RD2.

Optional Feature:
- Macro: MW_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 at each rising clk where reset==1, W_valid=1 and W_stall=0. It wraps modulo 2^32.
- Not defined: retire_cnt is constant 0 and no counter flops are synthesised. Port list is identical in both cases.

Decomposition:
- Shared package cpu_pkg: PC_RESET value, REG_ZERO=5'd0, GRF address width 5, data width 32.
- Sub-module grf_bypass: NREG x 32 array, one write port, two bypassed read ports, active-low synchronous clear.
- mw_writeback instantiates grf_bypass and owns the M/W register and the counter.

Test Plan:
- Hold reset=0 for 2 cycles, then release → W_PC=0x0000_3000, W_RegWrite=0, D_RD1 for A1=5 reads 0, retire_cnt=0.
- M_valid=1, M_A3=8, M_WD_W=0x1234_5678, M_RegWrite=1 at edge k → W_A3=8 after k; D_A1=8 reads 0x1234_5678 via bypass before k+1 and from GRF after k+1.
- M_A3=0, M_RegWrite=1, M_WD_W=0xFFFF_FFFF → W_RegWrite=0, W_A3=0; D_RD1 at A1=0 stays 0.
- W_stall=1 for 3 cycles with W holding a write to $9=0xAA → W_* unchanged; GRF[9] written only on the first unstalled edge; retire_cnt +1 once (with MW_RETIRE_CNT_EN).
- W_flush=1 and W_stall=1 together with a valid M write to $3 → bubble loaded (W_valid=0); GRF[3] unchanged.
- Drive reset=0 mid-stream while W_RegWrite=1 → no GRF write that edge; all registers 0 next cycle.
